// File: rtl/gpu_mem_arbiter.sv
// Round-robin OBI arbiter sharing the host memory port among NUM_REQ requesters.
// Granted requester IDs are queued in order so response beats route back.
module gpu_mem_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*4-1:0]            be_i,
  input  logic [NUM_REQ*32-1:0]           addr_i,
  input  logic [NUM_REQ*32-1:0]           wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [31:0]                     rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [3:0]                      mem_be_o,
  output logic [31:0]                     mem_addr_o,
  output logic [31:0]                     mem_wdata_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [31:0]                     mem_rdata_i,
  output logic                            err_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  win;
  logic             win_vld;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ID_W-1:0]  head;

  // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    int sum;
    win     = '0;
    win_vld = 1'b0;
    sum     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(rr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (!win_vld && req_i[ID_W'(sum)]) begin
        win_vld = 1'b1;
        win     = ID_W'(sum);
      end
    end
  end

  assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_q];

  assign mem_req_o = rst_ni && win_vld && !full;
  assign push      = mem_req_o && mem_gnt_i;
  assign pop       = rst_ni && mem_rvalid_i && !empty;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (win_vld) begin
      mem_we_o    = we_i[win];
      mem_be_o    = be_i[{win, 2'b00} +: 4];
      mem_addr_o  = addr_i[{win, 5'b00000} +: 32];
      mem_wdata_o = wdata_i[{win, 5'b00000} +: 32];
    end
  end

  assign gnt_o    = push ? (NUM_REQ'(1) << win)  : '0;
  assign rvalid_o = pop  ? (NUM_REQ'(1) << head) : '0;
  assign rdata_o  = mem_rdata_i;

  assign err_o         = err_q;
  assign outstanding_o = cnt_q;

  always_comb begin
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      rr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (mem_rvalid_i && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // ID storage needs no reset: only entries behind the write pointer are read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= win;
  end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Randomized scoreboard bench for gpu_mem_arbiter against a queue-based
// reference of the round-robin and in-order response rules.
module tb_gpu_mem_arbiter;

  localparam int N   = 4;
  localparam int MAX = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*4-1:0] be;
  logic [N*32-1:0] addr;
  logic [N*32-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [31:0]    rdata;
  logic           mreq;
  logic           mwe;
  logic [3:0]     mbe;
  logic [31:0]    maddr;
  logic [31:0]    mwdata;
  logic           mgnt;
  logic           mrv;
  logic [31:0]    mrdata;
  logic           err;
  logic [2:0]     outst;

  int tests = 0;
  int fails = 0;

  // reference model state
  int mrr  = 0;
  int mcnt = 0;
  bit merr = 0;
  int exp_q[$];

  gpu_mem_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
    .err_o(err), .outstanding_o(outst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the expected requester ID on every beat.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rvalid_in_reset", rvalid, 0);
    end else if (mrv) begin
      if (exp_q.size() > 0) begin
        int id;
        id = exp_q.pop_front();
        chk("rvalid_route", rvalid, 1 << id);
        chk("rdata", rdata, mrdata);
      end else begin
        chk("rvalid_dropped", rvalid, 0);
      end
    end else begin
      chk("rvalid_idle", rvalid, 0);
    end
  end

  // Request-side checker and model update; runs just after the monitor.
  initial forever begin
    int w;
    bit exp_req;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      chk("mem_req_in_reset", mreq, 0);
      chk("gnt_in_reset", gnt, 0);
      mrr  = 0;
      mcnt = 0;
      merr = 0;
      exp_q.delete();
    end else begin
      chk("outstanding", outst, mcnt);
      chk("err", err, merr);
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req[(mrr + i) % N]) w = (mrr + i) % N;
      end
      exp_req = (w >= 0) && (mcnt < MAX);
      chk("mem_req", mreq, exp_req);
      if (w >= 0) begin
        chk("mem_addr", maddr, addr[w*32 +: 32]);
        chk("mem_fields", {mwe, mbe, mwdata},
            {we[w], be[w*4 +: 4], wdata[w*32 +: 32]});
      end else begin
        chk("mem_fields_idle", {mwe, mbe, maddr, mwdata}, 0);
      end
      if (exp_req && mgnt) begin
        chk("gnt", gnt, 1 << w);
        exp_q.push_back(w);
        mrr = (w + 1) % N;
      end else begin
        chk("gnt_none", gnt, 0);
      end
      if (mrv && mcnt == 0) merr = 1;
      mcnt = mcnt + ((exp_req && mgnt) ? 1 : 0) - ((mrv && mcnt > 0) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic cyc(input logic [N-1:0] r, input logic g, input logic v,
                     input logic [31:0] d);
    req    = r;
    mgnt   = g;
    mrv    = v;
    mrdata = d;
    we     = N'($urandom);
    be     = (N*4)'($urandom);
    for (int i = 0; i < N; i++) begin
      addr[i*32 +: 32]  = $urandom;
      wdata[i*32 +: 32] = $urandom;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    // fill the FIFO, fifth cycle must be blocked
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1, 0, 0);
    // drain in order with tagged data
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 32'hA0 + i);
    cyc(0, 0, 0, 0);
    // alternating 0/2 with response the following cycle
    cyc(4'b0101, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0101, 1, 1, $urandom);
    cyc(0, 0, 1, $urandom);
    // stalled downstream grant
    for (int i = 0; i < 3; i++) cyc(4'b0010, 0, 0, 0);
    cyc(4'b0010, 1, 0, 0);
    cyc(0, 0, 1, $urandom);
    // orphan beat sets the sticky error
    cyc(0, 0, 1, 32'hDEAD);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    // randomized traffic, responses only when something is outstanding
    for (int i = 0; i < 400; i++) begin
      cyc(N'($urandom), 1'($urandom_range(0, 3) != 0),
          (mcnt > 0) && ($urandom_range(0, 2) != 0), $urandom);
    end
    // reset with transactions in flight, then a stale response
    for (int i = 0; i < 3; i++) cyc(4'b1111, 1, 0, 0);
    rst_n = 1'b0;
    cyc(4'b1111, 1, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'hBEEF);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
